imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 70 +++++++
 tb/tb_imem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates CPU fetch and loader write access to a single-port instruction memory; define IMEM_ARB_ROUND_ROBIN_EN for round-robin contention
module imem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_wdata,
  output logic              load_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        state,
  output logic              fault
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;
  state_e state_q, state_d;
  logic   fault_q, fault_d, rvalid_q;
  logic   fetch_ok, misaligned;
  logic   unused_bits;
  assign unused_bits = ^{fetch_addr[31:ADDR_W+2], load_addr[31:ADDR_W+2], load_addr[1:0]};
  assign misaligned = state_q == RUN && fetch_req && fetch_addr[1:0] != 2'b00;
  assign fetch_ok   = state_q == RUN && fetch_req && fetch_addr[1:0] == 2'b00;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic prio_q;
  // prio_q set means the loader wins the next contention
  assign fetch_gnt = !rst && fetch_ok && !(load_req && prio_q);
  // remember who won the last contention so the other side wins the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_q <= 1'b0;
    else if (fetch_ok && load_req) prio_q <= fetch_gnt;
`else
  assign fetch_gnt = !rst && fetch_ok;
`endif
  assign load_gnt  = !rst && load_req && !fetch_gnt;
  assign mem_en    = fetch_gnt || load_gnt;
  assign mem_we    = load_gnt;
  assign mem_addr  = load_gnt ? load_addr[ADDR_W+1:2] : fetch_gnt ? fetch_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = load_gnt ? load_wdata : '0;
  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? mem_rdata : '0;
  assign state = state_q;
  assign fault = fault_q;
  // next state: boot ends on boot_done, a misaligned fetch traps into FAULT for good
  always_comb begin
    state_d = state_q;
    fault_d = fault_q | misaligned;
    state_d = (state_q == BOOT && boot_done) ? RUN : misaligned ? FAULT : state_q;
  end
  // state registers; read data is valid the cycle after a fetch grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= BOOT;
      fault_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      rvalid_q <= fetch_gnt;
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed stimulus with a per-cycle reference model of the arbiter
module tb_imem_arbiter;
  logic        clk = 1'b0, rst = 1'b1, boot_done = 1'b0, fetch_req = 1'b0, load_req = 1'b0;
  logic [31:0] fetch_addr = '0, load_addr = '0, load_wdata = '0, mem_rdata;
  logic        fetch_gnt, fetch_rvalid, load_gnt, mem_en, mem_we, fault;
  logic [31:0] fetch_rdata, mem_wdata;
  logic [13:0] mem_addr;
  logic [1:0]  state;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] mem [16384];
  logic [31:0] ref_mem [16384];
  int          m_state, m_last;
  logic        m_fault, m_pend;
  logic [31:0] m_data;
  logic [3:0]  exp_pat;

  imem_arbiter dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = nothing granted, 1 = fetch, 2 = load
  function automatic int exp_win();
    logic f;
    if (rst) return 0;
    if (m_state != 1) return load_req ? 2 : 0;
    f = fetch_req && fetch_addr[1:0] == 2'b00;
    if (f && load_req) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      return m_last == 1 ? 2 : 1;
`else
      return 1;
`endif
    end
    return f ? 1 : load_req ? 2 : 0;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_state <= 0;
      m_fault <= 1'b0;
      m_pend  <= 1'b0;
      m_data  <= '0;
      m_last  <= 2;
    end else begin
      m_pend <= exp_win() == 1;
      if (exp_win() == 1) m_data <= ref_mem[fetch_addr[15:2]];
      if (exp_win() == 2) ref_mem[load_addr[15:2]] <= load_wdata;
      if (m_state == 0 && boot_done) m_state <= 1;
      else if (m_state == 1 && fetch_req && fetch_addr[1:0] != 2'b00) begin
        m_state <= 2;
        m_fault <= 1'b1;
      end
      if (m_state == 1 && fetch_req && fetch_addr[1:0] == 2'b00 && load_req) m_last <= exp_win();
    end

  always @(negedge clk) begin
    chk("fetch_gnt", 32'(fetch_gnt), 32'(exp_win() == 1));
    chk("load_gnt", 32'(load_gnt), 32'(exp_win() == 2));
    chk("mem_en", 32'(mem_en), 32'(exp_win() != 0));
    chk("mem_we", 32'(mem_we), 32'(exp_win() == 2));
    chk("mem_addr", 32'(mem_addr), exp_win() == 1 ? 32'(fetch_addr[15:2]) : exp_win() == 2 ? 32'(load_addr[15:2]) : 32'd0);
    chk("mem_wdata", mem_wdata, exp_win() == 2 ? load_wdata : 32'd0);
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_pend));
    chk("fetch_rdata", fetch_rdata, m_pend ? m_data : 32'd0);
    chk("state", 32'(state), 32'(m_state));
    chk("fault", 32'(fault), 32'(m_fault));
  end

  initial begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    exp_pat = 4'b1010;
`else
    exp_pat = 4'b1111;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    load_req = 1'b1; load_addr = 32'h10; load_wdata = 32'hDEADBEEF;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    chk("boot_load_gnt", 32'(load_gnt), 32'd1);
    chk("boot_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("boot_mem_we", 32'(mem_we), 32'd1);
    chk("boot_mem_addr", 32'(mem_addr), 32'd4);
    @(posedge clk); #1;
    load_req = 1'b0; fetch_req = 1'b0; boot_done = 1'b1;
    @(negedge clk);
    chk("boot_done_cycle_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    boot_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    chk("run_state", 32'(state), 32'd1);
    chk("run_fetch_gnt", 32'(fetch_gnt), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("first_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("first_rdata", fetch_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    load_req = 1'b1; load_addr = 32'h40; load_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contend_fetch_gnt", 32'(fetch_gnt), 32'(exp_pat[3-i]));
      chk("contend_load_gnt", 32'(load_gnt), 32'(!exp_pat[3-i]));
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    load_addr = 32'h20; load_wdata = 32'h12345678;
    @(posedge clk); #1;
    load_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h20;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("raw_rdata", fetch_rdata, 32'h12345678);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h22;
    @(negedge clk);
    chk("misalign_gnt", 32'(fetch_gnt), 32'd0);
    chk("misalign_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    fetch_addr = 32'h10; boot_done = 1'b1;
    @(negedge clk);
    chk("fault_state", 32'(state), 32'd2);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_fetch_gnt", 32'(fetch_gnt), 32'd0);
    @(posedge clk); #1;
    boot_done = 1'b0; load_req = 1'b1; load_addr = 32'h30; load_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("fault_load_gnt", 32'(load_gnt), 32'd1);
    chk("fault_fetch_gnt2", 32'(fetch_gnt), 32'd0);
    chk("fault_sticky", 32'(state), 32'd2);
    @(posedge clk); #1;
    fetch_req = 1'b0; load_req = 1'b0; rst = 1'b1;
    #1 chk("rst_fault_clear", 32'(fault), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; boot_done = 1'b1;
    @(posedge clk); #1;
    boot_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    chk("pre_rst_fetch_gnt", 32'(fetch_gnt), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    chk("pre_rst_rvalid", 32'(fetch_rvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rdata", fetch_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(fetch_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
